qdi2bin_e1of2_fifo: RTL and testbench
=====================================

// Module: qdi2bin_e1of2_fifo
// PURPOSE
//  Bridges an NCH-bit e1of2 (dual-rail, enable-acknowledged) QDI channel into a clocked binary stream.
//  Detects completion across all rails, captures the word into a DEPTH-entry FIFO and acknowledges via Le.
//  Presents words to clocked consumers with valid/ready. Sits on the QDI->testbench/synchronous boundary.
// PARAMETERS
//  NCH      8  number of dual-rail bits per token (>=1)
//  DEPTH    4  FIFO entries (power of 2, >=2)
//  SYNC     2  synchronizer flops on completion/neutral detect (>=2)
// PORTS
//  CLK     in   1         sampling/consumer clock, rising edge
//  RESET   in   1         reset, asynchronous, active-low
//  L       in   2*NCH     rails; bit i = {L[2i+1],L[2i]}: 01=0, 10=1, 00=neutral, 11=illegal
//  Le      out  1         enable to QDI sender; low = token accepted, high = ready for next token
//  dout    out  NCH       binary head-of-FIFO word
//  valid   out  1         dout valid
//  ready   in   1         consumer accepts dout when valid&&ready at CLK
//  count   out  clog2(DEPTH)+1  FIFO occupancy
//  err     out  1         sticky: illegal code (11) captured in some token
// BEHAVIOUR
//  Reset (RESET low, async): Le=0, valid=0, dout=0, count=0, err=0, FSM=IDLE, pointers=0, sync flops=0.
//   On the first CLK after RESET rises: Le=1.
//  Detect (combinational on L): all_valid = every pair has exactly one or two rails high; all_neutral = every pair 00.
//   Both are passed through SYNC flops -> v_s, n_s. Raw L is never used for control directly.
//  FSM:
//   IDLE: Le=1. If v_s && count<DEPTH -> CAPTURE. If v_s && full -> stay; Le held high (backpressure);
//    the token is held by the sender.
//   CAPTURE (1 cycle): write decoded word (bit i = L[2i+1]) at wr_ptr. Pair 11 -> bit=1, err<=1.
//    Le<=0 -> WAIT_N.
//   WAIT_N: Le=0 until n_s -> IDLE (Le<=1).
//  Latency: last rail rise -> Le fall = SYNC+1 CLK. Neutral -> Le rise = SYNC+1 CLK.
//   Write -> valid = 1 CLK (registered count).
//  FIFO: wr_ptr/rd_ptr clog2(DEPTH) bits, wrap modulo DEPTH. Pop on valid&&ready. valid = (count!=0).
//   dout = mem[rd_ptr], and dout=0 when empty. Simultaneous push+pop: count unchanged, both pointers advance.
//   Pop with count==0 is ignored. Push never occurs while full (FSM guard).
//  Partial token (some pairs neutral) is not all_valid -> no capture. Pair 11 is counted valid so the
//   handshake completes, and is flagged in err.
//  Rails returning to neutral before CAPTURE (protocol violation): v_s drops, FSM stays IDLE, nothing written.
//  RESET mid-token: all state cleared immediately. Le=0 until the first CLK after release.
//   The sender must return to neutral, and the block waits for all_valid again.
//  err clears only on reset.
// STRUCTURE
//  Shared package qdi_pkg: E1OF2_NEUTRAL=2'b00, E1OF2_ZERO=2'b01, E1OF2_ONE=2'b10, E1OF2_ILLEGAL=2'b11;
//   FSM state enum {IDLE,CAPTURE,WAIT_N}; function e1of2_decode.
//  Sub-module: qdi_sync_fifo (DEPTH x NCH, push/pop/count/full/empty). FSM, detect and sync stay in the top.
// TESTING
//  1 Reset: hold RESET low 3 CLK -> Le=0, valid=0, count=0, err=0. Release -> Le=1 next CLK.
//  2 Single token NCH=8, L encodes 8'hA5 -> Le falls 3 CLK later (SYNC=2). Set L=0 -> Le rises 3 CLK later.
//    dout=8'hA5 with valid=1, ready=1 pops it -> count=0.
//  3 Backpressure: ready=0, send 5 tokens 0x01..0x05 with DEPTH=4 -> count=4 and Le stays 1 on token 5.
//    Pop one -> token 5 captured. Drain order 01,02,03,04,05.
//  4 Partial token: raise pairs 0..6 only -> Le stays 1 for 20 CLK. Raise pair 7 -> capture proceeds.
//  5 Illegal: pair 3 = 11, rest encode 0 -> word 8'h08 written, err=1, handshake completes. err stays 1 afterwards.
//  6 Reset mid-token in WAIT_N with count=2 -> count=0, valid=0 immediately. Next token captured normally after release.
//  Continuous push+pop at full throughput -> count steady, no loss or duplication (scoreboard).

Source files
------------

// File: rtl/qdi_pkg.sv
// Shared e1of2 rail codes, bridge FSM states and the per-pair decode helper.
package qdi_pkg;

    localparam logic [1:0] E1OF2_NEUTRAL = 2'b00;
    localparam logic [1:0] E1OF2_ZERO    = 2'b01;
    localparam logic [1:0] E1OF2_ONE     = 2'b10;
    localparam logic [1:0] E1OF2_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WAIT_N  = 2'd2
    } qdi_state_e;

    // The data bit is the "one" rail, so an illegal 11 pair reads back as 1.
    function automatic logic e1of2_decode(input logic [1:0] pair);
        return pair[1];
    endfunction

endpackage

// File: rtl/qdi2bin_e1of2_fifo_if.sv
// Dual-rail input channel plus the clocked valid/ready output stream of the bridge.
interface qdi2bin_e1of2_fifo_if #(
    parameter int NCH   = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [2*NCH-1:0] L;
    logic             Le;
    logic [NCH-1:0]   dout;
    logic             valid;
    logic             ready;
    logic [CW-1:0]    count;
    logic             err;

    modport slave  (input L, ready, output Le, dout, valid, count, err);
    modport master (output L, ready, input Le, dout, valid, count, err);
endinterface

// File: rtl/qdi_sync_fifo.sv
// DEPTH x W synchronous FIFO with registered occupancy; reads zero when empty.
module qdi_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop_ok;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign w_pop_ok = i_pop && !o_empty;
    assign o_count  = r_count;
    assign o_dout   = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_din;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/qdi2bin_e1of2_fifo.sv
// e1of2 QDI receiver: synchronized completion/neutral detect, capture FSM driving Le,
// and a FIFO that presents captured words on a clocked valid/ready port.
module qdi2bin_e1of2_fifo #(
    parameter int NCH   = 8,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    qdi2bin_e1of2_fifo_if.slave   bus
);
    import qdi_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [NCH-1:0]  w_word;
    logic [NCH-1:0]  w_ill;
    logic [NCH-1:0]  w_pair_v;
    logic            w_all_valid;
    logic            w_all_neutral;
    logic [SYNC-1:0] r_v_sync;
    logic [SYNC-1:0] r_n_sync;
    logic            w_v_s;
    logic            w_n_s;

    qdi_state_e      r_state;
    logic            r_le;
    logic [NCH-1:0]  r_word;
    logic            r_word_ill;
    logic            r_err;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [NCH-1:0]  w_dout;

    for (genvar i = 0; i < NCH; i++) begin : g_pair
        logic [1:0] w_p;
        assign w_p         = bus.L[2*i +: 2];
        assign w_word[i]   = e1of2_decode(w_p);
        assign w_ill[i]    = (w_p == E1OF2_ILLEGAL);
        assign w_pair_v[i] = (w_p != E1OF2_NEUTRAL);
    end

    assign w_all_valid   = &w_pair_v;
    assign w_all_neutral = ~|w_pair_v;

    // Only the synchronized detects steer the FSM; raw rails are sampled solely as data.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_v_sync <= '0;
            r_n_sync <= '0;
        end else begin
            r_v_sync <= {r_v_sync[SYNC-2:0], w_all_valid};
            r_n_sync <= {r_n_sync[SYNC-2:0], w_all_neutral};
        end
    end

    assign w_v_s = r_v_sync[SYNC-1];
    assign w_n_s = r_n_sync[SYNC-1];

    // Word is latched as Le drops so a fast sender going neutral cannot corrupt it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= IDLE;
            r_le       <= 1'b0;
            r_word     <= '0;
            r_word_ill <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_v_s && !w_full) begin
                        r_word     <= w_word;
                        r_word_ill <= |w_ill;
                        r_le       <= 1'b0;
                        r_state    <= CAPTURE;
                    end else begin
                        r_le <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (r_word_ill)
                        r_err <= 1'b1;
                    r_state <= WAIT_N;
                end
                WAIT_N: begin
                    if (w_n_s) begin
                        r_le    <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_push = (r_state == CAPTURE);
    assign w_pop  = !w_empty && bus.ready;

    qdi_sync_fifo #(.W(NCH), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_push  (w_push),
        .i_din   (r_word),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.Le    = r_le;
    assign bus.dout  = w_dout;
    assign bus.valid = !w_empty;
    assign bus.count = w_count;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_qdi2bin_e1of2_fifo.sv
// Bench for the e1of2 bridge: directed handshake/latency cases, then random tokens vs a queue model.
module tb_qdi2bin_e1of2_fifo;
    localparam int NCH   = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int NRND  = 60;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    qdi2bin_e1of2_fifo_if #(.NCH(NCH), .DEPTH(DEPTH)) bus ();

    qdi2bin_e1of2_fifo #(.NCH(NCH), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [NCH-1:0] q[$];
    int popped = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*NCH-1:0] enc(input logic [NCH-1:0] w, input logic [NCH-1:0] ill,
                                             input logic [NCH-1:0] present);
        logic [2*NCH-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!present[i])  r[2*i +: 2] = 2'b00;
            else if (ill[i])  r[2*i +: 2] = 2'b11;
            else              r[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    // Counts falling CLK edges until Le reaches v; -1 on timeout.
    task automatic wait_le(input logic v, input int max, output int cyc);
        cyc = 0;
        while (bus.Le !== v) begin
            if (cyc >= max) begin
                cyc = -1;
                return;
            end
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic send(input logic [NCH-1:0] w, input logic [NCH-1:0] ill, output int lf, output int lr);
        bus.L = enc(w, ill, '1);
        wait_le(1'b0, 400, lf);
        bus.L = '0;
        wait_le(1'b1, 400, lr);
    endtask

    task automatic pop1();
        bus.ready = 1'b1;
        @(negedge CLK);
        bus.ready = 1'b0;
    endtask

    initial begin
        int lf, lr, stayed;
        bus.L     = '0;
        bus.ready = 1'b0;
        RESET     = 1'b1;
        #2 RESET  = 1'b0;

        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_le", bus.Le, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_dout", bus.dout, 0);
        RESET = 1'b1;
        @(negedge CLK);
        chk("rel_le", bus.Le, 1);

        // single token and handshake latency
        send(8'hA5, 8'h00, lf, lr);
        chk("tok_fall_lat", lf, SYNC + 1);
        chk("tok_rise_lat", lr, SYNC + 1);
        chk("tok_valid", bus.valid, 1);
        chk("tok_dout", bus.dout, 8'hA5);
        chk("tok_count", bus.count, 1);
        pop1();
        chk("tok_pop_count", bus.count, 0);
        chk("tok_pop_valid", bus.valid, 0);
        chk("tok_empty_dout", bus.dout, 0);

        // backpressure with a full FIFO
        for (int k = 1; k <= 4; k++) begin
            send(NCH'(k), 8'h00, lf, lr);
            chk("bp_to", (lf < 0) || (lr < 0), 0);
        end
        chk("bp_full_count", bus.count, DEPTH);
        bus.L = enc(8'h05, 8'h00, '1);
        stayed = 1;
        repeat (10) begin
            @(negedge CLK);
            if (bus.Le !== 1'b1) stayed = 0;
        end
        chk("bp_le_held", stayed, 1);
        chk("bp_count_held", bus.count, DEPTH);
        chk("bp_head", bus.dout, 8'h01);
        pop1();
        wait_le(1'b0, 20, lf);
        chk("bp_tok5_fall", lf < 0, 0);
        bus.L = '0;
        wait_le(1'b1, 20, lr);
        chk("bp_tok5_rise", lr < 0, 0);
        bus.ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk("bp_drain", bus.dout, k);
            @(negedge CLK);
        end
        bus.ready = 1'b0;
        chk("bp_drained", bus.count, 0);

        // partial token holds off capture
        bus.L = enc(8'h3C, 8'h00, 8'h7F);
        stayed = 1;
        repeat (20) begin
            @(negedge CLK);
            if (bus.Le !== 1'b1) stayed = 0;
        end
        chk("part_le_held", stayed, 1);
        chk("part_count", bus.count, 0);
        bus.L = enc(8'h3C, 8'h00, 8'hFF);
        wait_le(1'b0, 20, lf);
        chk("part_fall_lat", lf, SYNC + 1);
        bus.L = '0;
        wait_le(1'b1, 20, lr);
        chk("part_dout", bus.dout, 8'h3C);
        pop1();

        // illegal pair
        chk("ill_err_before", bus.err, 0);
        send(8'h00, 8'h08, lf, lr);
        chk("ill_handshake", (lf < 0) || (lr < 0), 0);
        chk("ill_dout", bus.dout, 8'h08);
        chk("ill_err", bus.err, 1);
        pop1();
        repeat (3) @(negedge CLK);
        chk("ill_err_sticky", bus.err, 1);

        // reset while waiting for neutral
        send(8'h11, 8'h00, lf, lr);
        send(8'h22, 8'h00, lf, lr);
        chk("mid_count2", bus.count, 2);
        bus.L = enc(8'h33, 8'h00, '1);
        wait_le(1'b0, 20, lf);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("mid_count", bus.count, 0);
        chk("mid_valid", bus.valid, 0);
        chk("mid_le", bus.Le, 0);
        chk("mid_err", bus.err, 0);
        bus.L = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("mid_rel_le", bus.Le, 1);
        send(8'h44, 8'h00, lf, lr);
        chk("mid_next_dout", bus.dout, 8'h44);
        chk("mid_next_count", bus.count, 1);
        pop1();

        // random tokens against queue model; second half with ready held high
        fork
            begin : sender
                logic [NCH-1:0] w;
                int f, r;
                for (int n = 0; n < NRND; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge CLK);
                    w = NCH'($urandom);
                    bus.L = enc(w, '0, '1);
                    wait_le(1'b0, 400, f);
                    chk("rnd_fall_to", f < 0, 0);
                    if (f < 0) break;
                    q.push_back(w);
                    bus.L = '0;
                    wait_le(1'b1, 400, r);
                    chk("rnd_rise_to", r < 0, 0);
                    if (r < 0) break;
                end
            end
            begin : consumer
                int cyc;
                logic rdy;
                cyc = 0;
                while (popped < NRND && cyc < 20000) begin
                    @(negedge CLK);
                    cyc++;
                    if (bus.valid) begin
                        if (q.size() == 0) chk("rnd_spurious_valid", 1, 0);
                        else               chk("rnd_dout", bus.dout, q[0]);
                        chk("rnd_count_le_depth", bus.count <= DEPTH, 1);
                    end
                    rdy = (popped < NRND / 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                    bus.ready = rdy;
                    if (bus.valid && rdy && q.size() > 0) begin
                        void'(q.pop_front());
                        popped++;
                    end
                end
            end
        join
        bus.ready = 1'b0;
        chk("rnd_popped", popped, NRND);
        @(negedge CLK);
        chk("rnd_end_count", bus.count, 0);
        chk("rnd_end_model", q.size(), 0);
        chk("rnd_end_err", bus.err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
